sha3_nonce_feeder: RTL
======================

Name: sha3_nonce_feeder

Overview:
- Upstream stage of sha3_iterating_pipe12.
- Holds a 25-lane Keccak state template and patches an incrementing nonce into one lane.
- Drives the pipe's sample/gimme burst protocol: one matrix per accepted clock over a programmed nonce range.
- Per-slot valid/nonce tags go downstream so the result checker can pair hashes with nonces and discard padding slots.

Parameters:
- NONCE_LANE, 4: lane index 0..24 (row-major, a[0]..e[4]) that carries the nonce.
- NONCE_LSB, 32: bit offset of the nonce field inside the lane; NONCE_LSB+NONCE_WIDTH <= 64.
- NONCE_WIDTH, 32: nonce field width in bits.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous reset, active-high.
- start, in, 1: one-cycle pulse; captures template and range.
- tmpla, tmplb, tmplc, tmpld, tmple, in, 64 x5 each: template rows.
- nonce_first, in, NONCE_WIDTH: first nonce.
- nonce_count, in, NONCE_WIDTH: number of nonces; 0 means 2^NONCE_WIDTH.
- gimme, in, 1: from the pipe; high means the current matrix is consumed if a burst is active.
- sample, out, 1: to the pipe.
- rowa, rowb, rowc, rowd, rowe, out, 64 x5 each: matrix to the pipe.
- slot_valid, out, 1: the presented matrix carries a real nonce (0 = padding).
- slot_nonce, out, NONCE_WIDTH: nonce in the presented matrix.
- busy, out, 1: range not exhausted or burst still open.
- done, out, 1: one-cycle pulse when the last burst closes.

Behaviour:
- Reset values: sample=0, busy=0, done=0, slot_valid=0, slot_nonce=0, rows=0; state IDLE.
- Registered state: template, current nonce, remaining count (NONCE_WIDTH+1 bits).
- Row outputs: the template with bits [NONCE_LSB +: NONCE_WIDTH] of lane NONCE_LANE replaced by the current nonce. The replacement is combinational from registers; zero added latency into the pipe.
- IDLE:
  - start=1 captures all inputs next edge: remaining = nonce_count, or 2^NONCE_WIDTH if nonce_count is 0.
  - Go to ARM; busy=1 from the cycle after start.
  - start while not IDLE is ignored.
- ARM:
  - sample = gimme.
  - gimme=1 is the first accepted cycle: nonce++, remaining--, go to BURST.
  - gimme=0 waits in ARM.
- BURST:
  - The pipe consumes one matrix every cycle gimme=1, whatever sample is.
  - sample = gimme.
  - Each cycle with gimme=1:
    - remaining>0: slot_valid=1, nonce++ (wraps mod 2^NONCE_WIDTH), remaining--.
    - remaining==0: padding slot; slot_valid=0, matrix repeats the last nonce, counters hold.
  - gimme falling closes the burst.
    - remaining>0: go to WAIT.
    - remaining==0: go to IDLE, pulse done for 1 cycle, busy=0 from the next cycle.
- WAIT: the pipe is iterating; sample=0. Return to ARM when gimme rises; the same cycle counts as the ARM acceptance.
- slot_valid/slot_nonce describe the matrix presented in the same cycle; both are 0 when sample=0.
- Range straddling a burst boundary: the next burst resumes at the exact next nonce; no nonce is skipped or duplicated.
- Nonce wrap from 2^NONCE_WIDTH-1 to 0 is legal within a range.
- rst mid-burst: everything returns to reset values next edge. sample drops immediately on the registered path. The pipe's internal burst state is not our concern; the system resets both.
- start coincident with rst: rst wins.

Decomposition:
- Shared package sha3_pkg:
  - typedef lane_t (logic[63:0]).
  - typedef state_rows_t (5x5 lane_t).
  - Feeder state enum (IDLE, ARM, BURST, WAIT).
  - Localparam LANES=25.
- One sub-module: sha3_lane_patch, combinational, inserting the nonce field into the selected lane; reused by the downstream result checker for nonce reconstruction.

Test Plan:
- nonce_first=0x10, nonce_count=5, gimme held high 26 cycles: slots 1-5 valid with nonces 0x10..0x14 in lane 4 bits[63:32], slots 6-26 slot_valid=0 repeating 0x14, done pulses once on gimme fall.
- nonce_count=60 across bursts of 26 accepted cycles: bursts carry 0x0..0x19, 0x1A..0x33, 0x34..0x3B plus 18 padding slots; exactly 60 valid slots, no gaps or duplicates.
- nonce_first=0xFFFFFFFE, nonce_count=4: valid nonces FFFFFFFE, FFFFFFFF, 0, 1.
- Template with all lanes 0xA5A5A5A5A5A5A5A5, nonce 0x12345678: lane 4 = 0x12345678A5A5A5A5, all other lanes unchanged.
- rst asserted on the 7th slot of a burst: next cycle sample=0, busy=0, slot_valid=0; a fresh start works normally.
- start pulsed during BURST: ignored; range and nonce sequence unchanged.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared Keccak state types and feeder FSM encoding for the sha3 pipe front end.
// Types only; no logic and no latency.
package sha3_pkg;

  localparam int LANES         = 25;
  localparam int LANES_PER_ROW = 5;
  localparam int LANE_BITS     = 64;

  typedef logic [LANE_BITS-1:0] lane_t;
  // row_t[i] is lane i of that row, so a packed row maps straight onto a 320-bit port.
  typedef lane_t [LANES_PER_ROW-1:0] row_t;
  typedef row_t [LANES/LANES_PER_ROW-1:0] state_rows_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    BURST = 2'd2,
    WAIT  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/sha3_lane_patch.sv
// Overwrites the nonce field of one lane in a Keccak state; purely combinational.
// Zero latency, no flow control; shared by the feeder and the result checker.
module sha3_lane_patch
  import sha3_pkg::*;
#(
  parameter int NONCE_LANE  = 4,
  parameter int NONCE_LSB   = 32,
  parameter int NONCE_WIDTH = 32
) (
  input  state_rows_t            tmpl,
  input  logic [NONCE_WIDTH-1:0] nonce,
  output state_rows_t            patched
);

  // Lane index is row-major: lane k sits in row k/5, column k%5.
  localparam int ROW = NONCE_LANE / LANES_PER_ROW;
  localparam int COL = NONCE_LANE % LANES_PER_ROW;

  always_comb begin
    patched = tmpl;
    patched[ROW][COL][NONCE_LSB +: NONCE_WIDTH] = nonce;
  end

endmodule

// File: rtl/sha3_nonce_feeder.sv
// Feeds nonce-patched Keccak matrices into sha3_iterating_pipe12, one per gimme cycle.
// Zero latency from registers to rows; the pipe's gimme is the only backpressure.
module sha3_nonce_feeder
  import sha3_pkg::*;
#(
  parameter int NONCE_LANE  = 4,
  parameter int NONCE_LSB   = 32,
  parameter int NONCE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [319:0]           tmpla,
  input  logic [319:0]           tmplb,
  input  logic [319:0]           tmplc,
  input  logic [319:0]           tmpld,
  input  logic [319:0]           tmple,
  input  logic [NONCE_WIDTH-1:0] nonce_first,
  input  logic [NONCE_WIDTH-1:0] nonce_count,
  input  logic                   gimme,
  output logic                   sample,
  output logic [319:0]           rowa,
  output logic [319:0]           rowb,
  output logic [319:0]           rowc,
  output logic [319:0]           rowd,
  output logic [319:0]           rowe,
  output logic                   slot_valid,
  output logic [NONCE_WIDTH-1:0] slot_nonce,
  output logic                   busy,
  output logic                   done
);

  localparam int RW = NONCE_WIDTH + 1;

  feeder_state_t          state;
  state_rows_t            tmpl;
  state_rows_t            patched;
  logic [NONCE_WIDTH-1:0] nonce;
  logic [RW-1:0]          remaining;

  logic                   accept;
  logic                   has_work;
  logic [NONCE_WIDTH-1:0] nonce_adv;
  logic [RW-1:0]          remaining_adv;
  logic [RW-1:0]          range_len;

  // Outside IDLE the pipe takes the presented matrix on every gimme cycle.
  assign accept     = gimme && (state != IDLE);
  assign has_work   = (remaining != '0);
  assign sample     = accept;
  assign slot_valid = accept && has_work;
  assign slot_nonce = accept ? nonce : '0;

  // The nonce register always holds the nonce on display; it stays on the last
  // real nonce once the range drains so padding slots repeat it.
  always_comb begin
    nonce_adv     = nonce;
    remaining_adv = remaining;
    if (has_work) begin
      remaining_adv = remaining - RW'(1);
      if (remaining != RW'(1)) begin
        nonce_adv = nonce + NONCE_WIDTH'(1);
      end
    end
  end

  assign range_len = (nonce_count == '0) ? {1'b1, {NONCE_WIDTH{1'b0}}}
                                         : {1'b0, nonce_count};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tmpl      <= '0;
      nonce     <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tmpl[0]   <= tmpla;
            tmpl[1]   <= tmplb;
            tmpl[2]   <= tmplc;
            tmpl[3]   <= tmpld;
            tmpl[4]   <= tmple;
            nonce     <= nonce_first;
            remaining <= range_len;
            busy      <= 1'b1;
            state     <= ARM;
          end
        end
        // A rising gimme in WAIT is itself the first accepted slot of the burst.
        ARM, WAIT: begin
          if (gimme) begin
            nonce     <= nonce_adv;
            remaining <= remaining_adv;
            state     <= BURST;
          end
        end
        BURST: begin
          if (gimme) begin
            nonce     <= nonce_adv;
            remaining <= remaining_adv;
          end else if (has_work) begin
            state <= WAIT;
          end else begin
            state <= IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sha3_lane_patch #(
    .NONCE_LANE  (NONCE_LANE),
    .NONCE_LSB   (NONCE_LSB),
    .NONCE_WIDTH (NONCE_WIDTH)
  ) u_patch (
    .tmpl    (tmpl),
    .nonce   (nonce),
    .patched (patched)
  );

  assign rowa = patched[0];
  assign rowb = patched[1];
  assign rowc = patched[2];
  assign rowd = patched[3];
  assign rowe = patched[4];

endmodule
